dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Single-outstanding arbiter that shares the one data-memory port between the load path (LSU functional unit) and the committed-store drain path (store buffer). It grants one requester per transaction, routes the memory response back to the owning requester, and drops load responses that a pipeline flush has killed. Committed stores are never cancelled. Loads have priority, and a starvation counter bounds how long a waiting store can be passed over.

## Interface
Parameters:
- XLEN_P, default XLEN (32): data width.
- STARVE_LIMIT, default 4: number of consecutive load grants a waiting store tolerates before it takes priority. 0 means stores always have priority.

Ports:
- clk, in, 1: clock. One clock domain.
- rst_n, in, 1: asynchronous, active-low reset.
- flush_i, in, 1: pipeline flush. Kills in-flight and presented loads. Stores are unaffected.
- ld_req_valid_i, in, 1: load request.
- ld_req_ready_o, out, 1: load request accepted this cycle.
- ld_addr_i, in, 32: load byte address.
- ld_rvalid_o, out, 1: load response valid.
- ld_rdata_o, out, XLEN_P: raw load word.
- st_req_valid_i, in, 1: committed-store request.
- st_req_ready_o, out, 1: store accepted this cycle.
- st_addr_i, in, 32: store address.
- st_wdata_i, in, XLEN_P: store data, lane-aligned.
- st_wstrb_i, in, XLEN_P/8: byte strobes.
- st_done_o, out, 1: store write acknowledged.
- mem_req_valid_o, out, 1: memory request.
- mem_req_ready_i, in, 1: memory accepts the request.
- mem_we_o, out, 1: 1 = write.
- mem_addr_o, out, 32: request address.
- mem_wdata_o, out, XLEN_P: write data.
- mem_wstrb_o, out, XLEN_P/8: write strobes. All-zero on reads.
- mem_rvalid_i, in, 1: response strobe. Used for both read data and write acknowledge.
- mem_rdata_i, in, XLEN_P: read data.
- busy_o, out, 1: a transaction is outstanding (state != IDLE).

## Operation
- States: IDLE, WAIT_LD, WAIT_ST, WAIT_LD_KILLED.
- Requests are presented only in IDLE. In every other state mem_req_valid_o, ld_req_ready_o and st_req_ready_o are all 0.
- Effective requests in IDLE:
  - ld_eff = ld_req_valid_i && !flush_i.
  - st_eff = st_req_valid_i.
- Grant in IDLE:
  - If starve_cnt >= STARVE_LIMIT and st_eff, the store wins.
  - Otherwise, if ld_eff, the load wins.
  - Otherwise, if st_eff, the store wins.
- mem_req_valid_o = ld_eff || st_eff. The mux selects the granted requester:
  - Store granted: mem_we_o = 1, wdata/wstrb from the store port.
  - Load granted: mem_we_o = 0, wstrb = 0, wdata = 0.
- Granted ready = mem_req_ready_i. Non-granted ready = 0. A fire is valid && ready.
- Transitions:
  - IDLE, load fire -> WAIT_LD.
  - IDLE, store fire -> WAIT_ST.
  - WAIT_LD, mem_rvalid_i -> IDLE.
  - WAIT_LD, flush_i without mem_rvalid_i -> WAIT_LD_KILLED.
  - WAIT_LD_KILLED, mem_rvalid_i -> IDLE, response discarded.
  - WAIT_ST, mem_rvalid_i -> IDLE. Flush is ignored in this state.
- Outputs:
  - ld_rvalid_o = (state == WAIT_LD) && mem_rvalid_i && !flush_i.
  - ld_rdata_o = mem_rdata_i, passed through combinationally.
  - st_done_o = (state == WAIT_ST) && mem_rvalid_i.
- starve_cnt has width $clog2(STARVE_LIMIT+1), minimum 1.
  - Increments, saturating at STARVE_LIMIT, on a load fire while st_req_valid_i = 1.
  - Clears on a store fire.
  - Otherwise holds.
  - flush_i does not affect it.
- mem_rvalid_i in IDLE is a protocol violation. It is ignored with no state or output change.

## Timing
- Reset (asynchronous):
  - state = IDLE, starve_cnt = 0.
  - All valid, ready, done and busy outputs are 0. mem_we_o = 0, mem_wstrb_o = 0.
  - Address and data outputs are 0 when no requester is valid.
- The request path is combinational, from requester valid to mem_req_valid_o and from mem_req_ready_i to requester ready, within the same cycle.
- The response path is combinational, from mem_rvalid_i to ld_rvalid_o/st_done_o within the same cycle.
- Fire at cycle N gives busy_o = 1 from N+1. The response arrives at the earliest at N+1.
- After the response at cycle M, the state is IDLE at M+1, and the next fire is possible at M+1. Back-to-back throughput is one transaction per two cycles with 1-cycle memory.
- flush_i asserted in IDLE blocks the load grant that cycle. A valid store is still granted.
- flush_i coincident with mem_rvalid_i in WAIT_LD: ld_rvalid_o = 0 and the next state is IDLE.
- Reset mid-transaction returns to IDLE immediately. Any later stray mem_rvalid_i is ignored under the IDLE rule.

## Test plan
- Single load, 1-cycle memory:
  - Stimulus: ld_addr 0x100, mem_rdata 0xDEADBEEF.
  - Required: mem_we_o = 0, then ld_rvalid_o = 1 with 0xDEADBEEF one cycle later, st_done_o = 0.
- Single store:
  - Stimulus: addr 0x200, wdata 0x12345678, wstrb 0xF.
  - Required: mem_we_o = 1, mem_wstrb_o = 0xF, then st_done_o pulses once and ld_rvalid_o stays 0.
- Contention with STARVE_LIMIT = 4:
  - Stimulus: load and store both continuously valid.
  - Required grant order: L, L, L, L, S, L, L, L, L, S. starve_cnt returns to 0 after each S.
- Flush during WAIT_LD with 3-cycle memory:
  - Stimulus: flush_i on the cycle after the load fire.
  - Required: state goes to WAIT_LD_KILLED, ld_rvalid_o stays 0 when mem_rvalid_i arrives, and the next request is accepted the following cycle.
- Flush in IDLE with both requesters valid:
  - Required: the store is granted, ld_req_ready_o = 0. A flush during WAIT_ST still produces st_done_o = 1.
- Async reset asserted in WAIT_ST:
  - Required: busy_o = 0 and all outputs at their reset values immediately.
  - A later stray mem_rvalid_i produces no st_done_o or ld_rvalid_o.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the load path and the committed-store drain.
// One transaction outstanding at a time; loads win unless a waiting store has been passed over too often.
module dmem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int XLEN_P       = XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  ld_req_valid_i,
    output logic                  ld_req_ready_o,
    input  logic [31:0]           ld_addr_i,
    output logic                  ld_rvalid_o,
    output logic [XLEN_P-1:0]     ld_rdata_o,
    input  logic                  st_req_valid_i,
    output logic                  st_req_ready_o,
    input  logic [31:0]           st_addr_i,
    input  logic [XLEN_P-1:0]     st_wdata_i,
    input  logic [XLEN_P/8-1:0]   st_wstrb_i,
    output logic                  st_done_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [XLEN_P-1:0]     mem_wdata_o,
    output logic [XLEN_P/8-1:0]   mem_wstrb_o,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN_P-1:0]     mem_rdata_i,
    output logic                  busy_o
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] ST_IDLE           = 2'd0;
    localparam logic [1:0] ST_WAIT_LD        = 2'd1;
    localparam logic [1:0] ST_WAIT_ST        = 2'd2;
    localparam logic [1:0] ST_WAIT_LD_KILLED = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic in_idle, ld_eff, st_eff, ld_grant, st_grant, ld_fire, st_fire;

    always_comb begin
        // Requests are also held off while reset is asserted so every valid reads 0.
        in_idle  = rst_n && (state_q == ST_IDLE);
        ld_eff   = in_idle && ld_req_valid_i && !flush_i;
        st_eff   = in_idle && st_req_valid_i;
        st_grant = st_eff && ((starve_cnt_q >= LIMIT_C) || !ld_eff);
        ld_grant = ld_eff && !st_grant;
        ld_fire  = ld_grant && mem_req_ready_i;
        st_fire  = st_grant && mem_req_ready_i;
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_fire) state_d = ST_WAIT_LD;
                if (st_fire) state_d = ST_WAIT_ST;
            end
            ST_WAIT_LD: begin
                if (mem_rvalid_i)  state_d = ST_IDLE;
                else if (flush_i)  state_d = ST_WAIT_LD_KILLED;
            end
            ST_WAIT_ST:        if (mem_rvalid_i) state_d = ST_IDLE;
            ST_WAIT_LD_KILLED: if (mem_rvalid_i) state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase
        if (st_fire) begin
            starve_cnt_d = '0;
        end else if (ld_fire && st_req_valid_i && (starve_cnt_q < LIMIT_C)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign ld_req_ready_o  = ld_fire;
    assign st_req_ready_o  = st_fire;
    assign mem_req_valid_o = ld_eff || st_eff;
    assign mem_we_o        = st_grant;
    assign mem_addr_o      = st_grant ? st_addr_i : (ld_grant ? ld_addr_i : 32'd0);
    assign mem_wdata_o     = st_grant ? st_wdata_i : '0;
    assign mem_wstrb_o     = st_grant ? st_wstrb_i : '0;

    assign ld_rvalid_o = (state_q == ST_WAIT_LD) && mem_rvalid_i && !flush_i;
    assign ld_rdata_o  = mem_rdata_i;
    assign st_done_o   = (state_q == ST_WAIT_ST) && mem_rvalid_i;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model of the arbiter (outstanding owner + starvation count).
module tb_dmem_port_arbiter;

    localparam int XL    = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_i, ld_req_valid_i, st_req_valid_i, mem_req_ready_i, mem_rvalid_i;
    logic [31:0] ld_addr_i, st_addr_i;
    logic [XL-1:0] st_wdata_i, mem_rdata_i;
    logic [XL/8-1:0] st_wstrb_i;
    logic ld_req_ready_o, ld_rvalid_o, st_req_ready_o, st_done_o;
    logic mem_req_valid_o, mem_we_o, busy_o;
    logic [XL-1:0] ld_rdata_o, mem_wdata_o;
    logic [31:0] mem_addr_o;
    logic [XL/8-1:0] mem_wstrb_o;

    int total = 0;
    int bad   = 0;

    // transaction-level model state
    bit outstanding, owner_store, killed;
    int starve;

    // snapshot of outputs taken at the check point of the last cycle
    logic snap_we, snap_ldr, snap_str, snap_ldv, snap_std, snap_busy;
    logic [XL-1:0] snap_ldd;
    logic [XL/8-1:0] snap_wstrb;

    dmem_port_arbiter #(.XLEN_P(XL), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o), .ld_addr_i(ld_addr_i),
        .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
        .st_req_valid_i(st_req_valid_i), .st_req_ready_o(st_req_ready_o), .st_addr_i(st_addr_i),
        .st_wdata_i(st_wdata_i), .st_wstrb_i(st_wstrb_i), .st_done_o(st_done_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit ld_ok, st_ok, st_win, ld_win;
        logic e_req, e_we, e_ldr, e_str, e_ldv, e_std;
        logic [31:0] e_addr;
        logic [XL-1:0] e_wdata;
        logic [XL/8-1:0] e_wstrb;
        e_req = 0; e_we = 0; e_ldr = 0; e_str = 0; e_ldv = 0; e_std = 0;
        e_addr = '0; e_wdata = '0; e_wstrb = '0;
        if (!outstanding) begin
            ld_ok  = ld_req_valid_i && !flush_i;
            st_ok  = st_req_valid_i;
            st_win = st_ok && (starve >= LIMIT || !ld_ok);
            ld_win = ld_ok && !st_win;
            e_req  = ld_ok || st_ok;
            if (st_win) begin
                e_we = 1; e_addr = st_addr_i; e_wdata = st_wdata_i; e_wstrb = st_wstrb_i;
                e_str = mem_req_ready_i;
            end else if (ld_win) begin
                e_addr = ld_addr_i; e_ldr = mem_req_ready_i;
            end
        end else if (owner_store) begin
            e_std = mem_rvalid_i;
        end else begin
            e_ldv = mem_rvalid_i && !killed && !flush_i;
        end
        chk("mem_req_valid", mem_req_valid_o, e_req);
        chk("mem_we", mem_we_o, e_we);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wdata", mem_wdata_o, e_wdata);
        chk("mem_wstrb", mem_wstrb_o, e_wstrb);
        chk("ld_ready", ld_req_ready_o, e_ldr);
        chk("st_ready", st_req_ready_o, e_str);
        chk("ld_rvalid", ld_rvalid_o, e_ldv);
        chk("ld_rdata", ld_rdata_o, mem_rdata_i);
        chk("st_done", st_done_o, e_std);
        chk("busy", busy_o, outstanding);
        snap_we = mem_we_o; snap_ldr = ld_req_ready_o; snap_str = st_req_ready_o;
        snap_ldv = ld_rvalid_o; snap_std = st_done_o; snap_busy = busy_o;
        snap_ldd = ld_rdata_o; snap_wstrb = mem_wstrb_o;
    endtask

    // Advance the model by one clock using the inputs the DUT sampled at that edge.
    task automatic model_update();
        bit ld_ok, st_win, fire;
        if (!outstanding) begin
            ld_ok  = ld_req_valid_i && !flush_i;
            st_win = st_req_valid_i && (starve >= LIMIT || !ld_ok);
            fire   = mem_req_ready_i && (st_win || ld_ok);
            if (fire) begin
                outstanding = 1; owner_store = st_win; killed = 0;
                if (st_win) starve = 0;
                else if (st_req_valid_i && starve < LIMIT) starve++;
            end
        end else if (mem_rvalid_i) begin
            outstanding = 0;
        end else if (!owner_store && flush_i) begin
            killed = 1;
        end
    endtask

    task automatic model_reset();
        outstanding = 0; owner_store = 0; killed = 0; starve = 0;
    endtask

    task automatic cycle();
        #3;
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        flush_i = 0; ld_req_valid_i = 0; st_req_valid_i = 0; mem_req_ready_i = 1; mem_rvalid_i = 0;
        ld_addr_i = '0; st_addr_i = '0; st_wdata_i = '0; st_wstrb_i = '0; mem_rdata_i = '0;
    endtask

    initial begin
        logic [9:0] grants, exp_grants;
        idle_inputs();
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single load, 1-cycle memory
        ld_req_valid_i = 1; ld_addr_i = 32'h100;
        cycle();
        chk("load_we", snap_we, 1'b0);
        chk("load_fire", snap_ldr, 1'b1);
        ld_req_valid_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        cycle();
        chk("load_rvalid", snap_ldv, 1'b1);
        chk("load_rdata", snap_ldd, 32'hDEADBEEF);
        chk("load_no_stdone", snap_std, 1'b0);
        $display("txn load addr=0x100 data=0x%08h", snap_ldd);
        mem_rvalid_i = 0;

        // single store
        st_req_valid_i = 1; st_addr_i = 32'h200; st_wdata_i = 32'h12345678; st_wstrb_i = 4'hF;
        cycle();
        chk("store_we", snap_we, 1'b1);
        chk("store_wstrb", snap_wstrb, 4'hF);
        st_req_valid_i = 0; mem_rvalid_i = 1;
        cycle();
        chk("store_done", snap_std, 1'b1);
        chk("store_no_ldrvalid", snap_ldv, 1'b0);
        mem_rvalid_i = 0;
        cycle();
        chk("store_done_once", snap_std, 1'b0);
        $display("txn store addr=0x200 data=0x12345678");

        // contention: both always valid, 1-cycle memory
        ld_req_valid_i = 1; st_req_valid_i = 1; ld_addr_i = 32'h300;
        st_addr_i = 32'h400; st_wdata_i = 32'hCAFEF00D; st_wstrb_i = 4'h3;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid_i = 0;
            cycle();
            grants[i] = snap_str;
            exp_grants[i] = (i % 5 == 4);
            mem_rvalid_i = 1;
            cycle();
            if (snap_str) chk("starve_cleared", 64'(dut.starve_cnt_q), 64'd0);
            $display("txn contention %0d grant=%s", i, snap_str ? "S" : "L");
        end
        chk("grant_order", grants, exp_grants);
        idle_inputs();

        // flush during WAIT_LD, 3-cycle memory
        ld_req_valid_i = 1; ld_addr_i = 32'h500;
        cycle();
        ld_req_valid_i = 0; flush_i = 1;
        cycle();
        flush_i = 0;
        cycle();
        chk("killed_busy", snap_busy, 1'b1);
        mem_rvalid_i = 1; mem_rdata_i = 32'h0BADF00D;
        cycle();
        chk("killed_no_rvalid", snap_ldv, 1'b0);
        mem_rvalid_i = 0; ld_req_valid_i = 1;
        cycle();
        chk("after_kill_accept", snap_ldr, 1'b1);
        ld_req_valid_i = 0; mem_rvalid_i = 1;
        cycle();
        mem_rvalid_i = 0;
        $display("txn killed load addr=0x500");

        // flush in IDLE with both valid, then flush during WAIT_ST
        flush_i = 1; ld_req_valid_i = 1; st_req_valid_i = 1;
        st_addr_i = 32'h600; st_wdata_i = 32'h55AA55AA; st_wstrb_i = 4'hC;
        cycle();
        chk("flush_st_grant", snap_str, 1'b1);
        chk("flush_no_ld", snap_ldr, 1'b0);
        ld_req_valid_i = 0; st_req_valid_i = 0; mem_rvalid_i = 1;
        cycle();
        chk("flush_st_done", snap_std, 1'b1);
        idle_inputs();
        $display("txn flushed-idle store addr=0x600");

        // async reset in WAIT_ST
        st_req_valid_i = 1; st_addr_i = 32'h700; st_wdata_i = 32'h1; st_wstrb_i = 4'h1;
        cycle();
        idle_inputs();
        chk("pre_reset_busy", busy_o, 1'b1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("reset_busy", busy_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_rvalid_i = 1;
        cycle();
        chk("stray_no_stdone", snap_std, 1'b0);
        chk("stray_no_ldv", snap_ldv, 1'b0);
        mem_rvalid_i = 0;
        $display("txn reset in WAIT_ST");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            flush_i         = ($urandom_range(7) == 0);
            ld_req_valid_i  = $urandom_range(1);
            st_req_valid_i  = $urandom_range(1);
            mem_req_ready_i = ($urandom_range(3) != 0);
            mem_rvalid_i    = ($urandom_range(2) == 0);
            ld_addr_i  = $urandom; st_addr_i = $urandom;
            st_wdata_i = $urandom; st_wstrb_i = 4'($urandom);
            mem_rdata_i = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
